// File: rtl/fir_ctrl_pkg.sv
// Shared types and status codes for the FIR run sequencer.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE
  } fir_ctrl_state_t;

  localparam logic [7:0] CHK_IDLE = 8'h00;
  localparam logic [7:0] CHK_RUN  = 8'hA5;
  localparam logic [7:0] CHK_DONE = 8'h5A;

endpackage

// File: rtl/fir_beat_counter.sv
// Stream beat counter: counts accepted beats up to the run length and flags
// the last beat and the exhausted condition.
module fir_beat_counter #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] cnt,
  output logic             at_last,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + LEN_W'(1);
    end
  end

  // cnt never exceeds len, so equality is the same as cnt >= len
  assign full    = (cnt == len);
  assign at_last = (cnt == len - LEN_W'(1));

endmodule

// File: rtl/fir_run_ctrl.sv
// FIR run sequencer: kicks the FIR, gates both streams for exactly cfg_len
// beats, waits for ap_done, and reports status, errors and run latency.
module fir_run_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10,
  parameter int CYC_W  = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        checkbits,
  output logic [CYC_W-1:0]  latency,
  output logic              fir_ap_start,
  input  logic              fir_ap_done,
  input  logic              src_tvalid,
  input  logic [DATA_W-1:0] src_tdata,
  output logic              src_tready,
  output logic              fir_ss_tvalid,
  output logic [DATA_W-1:0] fir_ss_tdata,
  output logic              fir_ss_tlast,
  input  logic              fir_ss_tready,
  input  logic              fir_sm_tvalid,
  input  logic [DATA_W-1:0] fir_sm_tdata,
  input  logic              fir_sm_tlast,
  output logic              fir_sm_tready,
  output logic              y_tvalid,
  output logic [DATA_W-1:0] y_tdata,
  input  logic              y_tready
);

  fir_ctrl_state_t  state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [CYC_W-1:0] cyc_cnt, cyc_inc;
  logic             done_seen;
  logic             in_stream, out_act, cnt_clr;
  logic             x_hs, y_hs;
  logic [LEN_W-1:0] x_cnt, y_cnt;
  logic             x_last, y_last, x_full, y_full;
  logic             x_fin, y_fin;

  assign in_stream = (state == S_STREAM);
  assign out_act   = in_stream || (state == S_WAIT_DONE);
  assign cnt_clr   = (state == S_START);

  assign fir_ss_tvalid = in_stream & src_tvalid & ~x_full;
  assign src_tready    = in_stream & fir_ss_tready & ~x_full;
  assign fir_ss_tdata  = src_tdata;
  assign fir_ss_tlast  = in_stream & x_last;

  assign y_tvalid      = out_act & fir_sm_tvalid & ~y_full;
  assign fir_sm_tready = out_act & y_tready & ~y_full;
  assign y_tdata       = fir_sm_tdata;

  assign x_hs = fir_ss_tvalid & fir_ss_tready;
  assign y_hs = y_tvalid & y_tready;

  fir_beat_counter #(.LEN_W(LEN_W)) u_x_cnt (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (cnt_clr),
    .inc     (x_hs),
    .len     (len_q),
    .cnt     (x_cnt),
    .at_last (x_last),
    .full    (x_full)
  );

  fir_beat_counter #(.LEN_W(LEN_W)) u_y_cnt (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (cnt_clr),
    .inc     (y_hs),
    .len     (len_q),
    .cnt     (y_cnt),
    .at_last (y_last),
    .full    (y_full)
  );

  // A path is finished once exhausted or while taking its final beat, so the
  // last beat and the state change share a cycle.
  assign x_fin = x_full | (x_last & x_hs);
  assign y_fin = y_full | (y_last & y_hs);

  assign cyc_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nxt    = state;
    fir_ap_start = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE:      if (start && (cfg_len != '0)) state_nxt = S_START;
      S_START: begin
        fir_ap_start = 1'b1;
        state_nxt    = S_STREAM;
      end
      S_STREAM:    if (x_fin && y_fin) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (done_seen || fir_ap_done) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cyc_cnt   <= '0;
      done_seen <= 1'b0;
      err       <= 1'b0;
      checkbits <= CHK_IDLE;
      latency   <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && start) begin
        if (cfg_len == '0) err <= 1'b1;
        else               len_q <= cfg_len;
      end

      if (y_hs && (fir_sm_tlast != y_last)) err <= 1'b1;

      // Held at zero while idle so the counter reads 0 in START
      if (state == S_IDLE) cyc_cnt <= '0;
      else                 cyc_cnt <= cyc_inc;

      if (state == S_IDLE)            done_seen <= 1'b0;
      else if (out_act && fir_ap_done) done_seen <= 1'b1;

      if (state == S_IDLE && state_nxt == S_START) checkbits <= CHK_RUN;

      // Latch the value the counter takes in the DONE cycle
      if (state_nxt == S_DONE) begin
        checkbits <= CHK_DONE;
        latency   <= cyc_inc;
      end
    end
  end

endmodule
